// File: rtl/wrf_pkg.sv
// Shared defaults, FSM state type and window-relative index helper for windowed_reg_file.
package wrf_pkg;

  localparam int unsigned WRF_DATA_W      = 16;
  localparam int unsigned WRF_NUM_PHYS    = 8;
  localparam int unsigned WRF_WIN_REGS    = 4;
  localparam int unsigned WRF_STRIDE      = 2;
  localparam int unsigned WRF_SPILL_WORDS = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSpill,
    StFill
  } wrf_state_e;

  function automatic int unsigned wrf_phys_idx(input int unsigned win, input int unsigned off,
                                               input int unsigned stride,
                                               input int unsigned nphys);
    return (win * stride + off) % nphys;
  endfunction

endpackage

// File: rtl/wrf_spill_stack.sv
// Spill stack for windowed_reg_file: word array plus stack pointer, one word moved per beat.
module wrf_spill_stack #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned BEAT_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_last,
  input  logic [BEAT_W-1:0] i_beat,
  input  logic [DATA_W-1:0] i_push_data,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [SPW-1:0]    r_sp;
  logic [AW-1:0]     w_push_idx;
  logic [AW-1:0]     w_pop_idx;

  assign w_push_idx = AW'(r_sp + SPW'(i_beat));
  // Pop reads the frame just below sp; sp itself only moves on the last beat.
  assign w_pop_idx  = AW'(r_sp - SPW'(STRIDE) + SPW'(i_beat));
  assign o_pop_data = r_mem[w_pop_idx];
  assign o_full     = (r_sp == SPW'(DEPTH));
  assign o_empty    = (r_sp == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '{default: '0};
      r_sp  <= '0;
    end else begin
      if (i_push) r_mem[w_push_idx] <= i_push_data;
      if (i_push && i_last)     r_sp <= r_sp + SPW'(STRIDE);
      else if (i_pop && i_last) r_sp <= r_sp - SPW'(STRIDE);
    end
  end

endmodule

// File: rtl/windowed_reg_file.sv
// Register-window file with overlapping windows and spill/fill to a stack.
// Define WRF_BYPASS_EN to forward same-cycle write data onto the read ports.
module windowed_reg_file
  import wrf_pkg::*;
#(
  parameter int unsigned DATA_W      = WRF_DATA_W,
  parameter int unsigned NUM_PHYS    = WRF_NUM_PHYS,
  parameter int unsigned WIN_REGS    = WRF_WIN_REGS,
  parameter int unsigned STRIDE      = WRF_STRIDE,
  parameter int unsigned SPILL_WORDS = WRF_SPILL_WORDS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [$clog2(WIN_REGS)-1:0]          r1_addr,
  input  logic [$clog2(WIN_REGS)-1:0]          r2_addr,
  output logic [DATA_W-1:0]                    r1,
  output logic [DATA_W-1:0]                    r2,
  input  logic [$clog2(WIN_REGS)-1:0]          wr_addr,
  input  logic [DATA_W-1:0]                    wr_data,
  input  logic                                 wr_en,
  input  logic                                 win_inc,
  input  logic                                 win_dec,
  output logic [$clog2(NUM_PHYS/STRIDE)-1:0]   cwp,
  output logic                                 busy,
  output logic                                 ovf,
  output logic                                 unf
);

  localparam int unsigned NUM_WIN = NUM_PHYS / STRIDE;
  localparam int unsigned CW      = $clog2(NUM_WIN);
  localparam int unsigned PW      = $clog2(NUM_PHYS);
  localparam int unsigned BW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [DATA_W-1:0] r_regs [NUM_PHYS];
  logic [CW-1:0]     r_cwp;
  logic [CW-1:0]     r_resident;
  logic [BW-1:0]     r_beat;
  wrf_state_e        r_state;
  logic              r_ovf;
  logic              r_unf;

  logic              w_idle, w_inc, w_dec, w_win_full, w_win_single, w_last;
  logic              w_sp_full, w_sp_empty;
  logic [CW-1:0]     w_mv_win;
  logic [PW-1:0]     w_r1_idx, w_r2_idx, w_wr_idx, w_mv_idx;
  logic [DATA_W-1:0] w_pop_data;

  assign w_idle       = (r_state == StIdle);
  assign w_inc        = w_idle && win_inc && !win_dec;
  assign w_dec        = w_idle && win_dec && !win_inc;
  assign w_win_full   = (r_resident == CW'(NUM_WIN - 1));
  assign w_win_single = (r_resident == CW'(1));
  assign w_last       = (r_beat == BW'(STRIDE - 1));

  // Spill drains the oldest resident window; fill restores into the current one.
  assign w_mv_win = (r_state == StSpill) ? CW'(r_cwp - r_resident + CW'(1)) : r_cwp;

  assign w_r1_idx = PW'(wrf_phys_idx(32'(r_cwp), 32'(r1_addr), STRIDE, NUM_PHYS));
  assign w_r2_idx = PW'(wrf_phys_idx(32'(r_cwp), 32'(r2_addr), STRIDE, NUM_PHYS));
  assign w_wr_idx = PW'(wrf_phys_idx(32'(r_cwp), 32'(wr_addr), STRIDE, NUM_PHYS));
  assign w_mv_idx = PW'(wrf_phys_idx(32'(w_mv_win), 32'(r_beat), STRIDE, NUM_PHYS));

  always_comb begin
`ifdef WRF_BYPASS_EN
    r1 = (wr_en && w_idle && (w_r1_idx == w_wr_idx)) ? wr_data : r_regs[w_r1_idx];
    r2 = (wr_en && w_idle && (w_r2_idx == w_wr_idx)) ? wr_data : r_regs[w_r2_idx];
`else
    r1 = r_regs[w_r1_idx];
    r2 = r_regs[w_r2_idx];
`endif
  end

  assign cwp  = r_cwp;
  assign busy = !w_idle;
  assign ovf  = r_ovf;
  assign unf  = r_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '{default: '0};
    end else begin
      if (w_idle && wr_en)     r_regs[w_wr_idx] <= wr_data;
      if (r_state == StFill)   r_regs[w_mv_idx] <= w_pop_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cwp      <= '0;
      r_resident <= CW'(1);
      r_beat     <= '0;
      r_state    <= StIdle;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_beat <= '0;
          if (w_inc && w_win_full && !w_sp_full) begin
            r_state <= StSpill;
          end else if (w_inc && w_win_full) begin
            r_ovf <= 1'b1;
          end else if (w_inc) begin
            r_cwp      <= r_cwp + CW'(1);
            r_resident <= r_resident + CW'(1);
          end else if (w_dec && w_win_single && !w_sp_empty) begin
            r_cwp   <= r_cwp - CW'(1);
            r_state <= StFill;
          end else if (w_dec && w_win_single) begin
            r_unf <= 1'b1;
          end else if (w_dec) begin
            r_cwp      <= r_cwp - CW'(1);
            r_resident <= r_resident - CW'(1);
          end
        end
        StSpill: begin
          if (w_last) begin
            r_cwp   <= r_cwp + CW'(1);
            r_beat  <= '0;
            r_state <= StIdle;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        StFill: begin
          if (w_last) begin
            r_beat  <= '0;
            r_state <= StIdle;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  wrf_spill_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (SPILL_WORDS),
    .STRIDE (STRIDE),
    .BEAT_W (BW)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_state == StSpill),
    .i_pop       (r_state == StFill),
    .i_last      (w_last),
    .i_beat      (r_beat),
    .i_push_data (r_regs[w_mv_idx]),
    .o_pop_data  (w_pop_data),
    .o_full      (w_sp_full),
    .o_empty     (w_sp_empty)
  );

endmodule

// File: tb/tb_windowed_reg_file.sv
// Directed self-checking bench for windowed_reg_file at default parameters.
module tb_windowed_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  r1_addr, r2_addr, wr_addr;
  logic [15:0] r1, r2, wr_data;
  logic        wr_en, win_inc, win_dec;
  logic [1:0]  cwp;
  logic        busy, ovf, unf;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  windowed_reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .r1_addr (r1_addr),
    .r2_addr (r2_addr),
    .r1      (r1),
    .r2      (r2),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .win_inc (win_inc),
    .win_dec (win_dec),
    .cwp     (cwp),
    .busy    (busy),
    .ovf     (ovf),
    .unf     (unf)
  );

  task automatic clr_in();
    wr_en = 1'b0; win_inc = 1'b0; win_dec = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    wr_addr = '0; wr_data = '0; r1_addr = '0; r2_addr = '0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One-cycle window request, then wait (bounded) for any spill/fill to finish.
  task automatic pulse(input logic inc, input logic dec, output int bc);
    win_inc = inc; win_dec = dec;
    @(negedge clk);
    win_inc = 1'b0; win_dec = 1'b0;
    bc = 0;
    while (busy && bc < 8) begin
      bc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (cwp !== 2'd0) begin bad++; $display("FAIL rst_cwp got=%0h want=0", cwp); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h want=0", busy); end
    total++; if (ovf !== 1'b0 || unf !== 1'b0) begin
      bad++; $display("FAIL rst_flags got=%0h%0h want=00", ovf, unf); end
    total++; if (dut.r_resident !== 2'd1) begin
      bad++; $display("FAIL rst_resident got=%0h want=1", dut.r_resident); end
    total++; if (dut.u_stack.r_sp !== 5'd0) begin
      bad++; $display("FAIL rst_sp got=%0h want=0", dut.u_stack.r_sp); end
    total++; if (r1 !== 16'h0) begin bad++; $display("FAIL rst_r1 got=%0h want=0", r1); end
  endtask

  task automatic test_overlap();
    do_reset();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h1234; win_inc = 1'b1;
    @(negedge clk);
    clr_in(); r1_addr = 2'd0;
    #1;
    total++; if (cwp !== 2'd1) begin bad++; $display("FAIL ovl_cwp got=%0h want=1", cwp); end
    total++; if (r1 !== 16'h1234) begin bad++; $display("FAIL ovl_r1 got=%0h want=1234", r1); end
    total++; if (dut.r_resident !== 2'd2) begin
      bad++; $display("FAIL ovl_resident got=%0h want=2", dut.r_resident); end
  endtask

  task automatic test_spill_fill();
    int bc;
    do_reset();
    write_reg(2'd0, 16'hA0A0);
    write_reg(2'd1, 16'hA1A1);
    pulse(1'b1, 1'b0, bc);
    pulse(1'b1, 1'b0, bc);
    total++; if (cwp !== 2'd2 || bc !== 0) begin
      bad++; $display("FAIL inc2 got=cwp %0h busy %0d want=cwp 2 busy 0", cwp, bc); end
    pulse(1'b1, 1'b0, bc);
    total++; if (bc !== 2) begin bad++; $display("FAIL spill_busy got=%0d want=2", bc); end
    total++; if (cwp !== 2'd3) begin bad++; $display("FAIL spill_cwp got=%0h want=3", cwp); end
    total++; if (dut.u_stack.r_sp !== 5'd2) begin
      bad++; $display("FAIL spill_sp got=%0d want=2", dut.u_stack.r_sp); end
    total++; if (dut.u_stack.r_mem[0] !== 16'hA0A0 || dut.u_stack.r_mem[1] !== 16'hA1A1) begin
      bad++; $display("FAIL spill_stack got=%0h,%0h want=a0a0,a1a1",
                      dut.u_stack.r_mem[0], dut.u_stack.r_mem[1]); end
    total++; if (dut.r_resident !== 2'd3) begin
      bad++; $display("FAIL spill_resident got=%0h want=3", dut.r_resident); end
    // At cwp=3, a2/a3 wrap onto phys 0/1, clobbering the spilled values.
    write_reg(2'd2, 16'h5555);
    write_reg(2'd3, 16'h6666);
    total++; if (dut.r_regs[0] !== 16'h5555) begin
      bad++; $display("FAIL wrap_write got=%0h want=5555", dut.r_regs[0]); end
    pulse(1'b0, 1'b1, bc);
    pulse(1'b0, 1'b1, bc);
    total++; if (cwp !== 2'd1 || dut.r_resident !== 2'd1) begin
      bad++; $display("FAIL dec2 got=cwp %0h res %0h want=cwp 1 res 1", cwp, dut.r_resident); end
    pulse(1'b0, 1'b1, bc);
    total++; if (bc !== 2) begin bad++; $display("FAIL fill_busy got=%0d want=2", bc); end
    total++; if (cwp !== 2'd0) begin bad++; $display("FAIL fill_cwp got=%0h want=0", cwp); end
    total++; if (dut.u_stack.r_sp !== 5'd0) begin
      bad++; $display("FAIL fill_sp got=%0d want=0", dut.u_stack.r_sp); end
    r1_addr = 2'd0; r2_addr = 2'd1;
    #1;
    total++; if (r1 !== 16'hA0A0 || r2 !== 16'hA1A1) begin
      bad++; $display("FAIL fill_data got=%0h,%0h want=a0a0,a1a1", r1, r2); end
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL fill_unf got=%0h want=0", unf); end
  endtask

  task automatic test_unf_ovf();
    int bc;
    do_reset();
    pulse(1'b0, 1'b1, bc);
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL unf_set got=%0h want=1", unf); end
    total++; if (cwp !== 2'd0 || dut.r_resident !== 2'd1 || bc !== 0) begin
      bad++; $display("FAIL unf_state got=cwp %0h res %0h busy %0d want=0 1 0",
                      cwp, dut.r_resident, bc); end
    repeat (10) pulse(1'b1, 1'b0, bc);
    total++; if (dut.u_stack.r_sp !== 5'd16 || ovf !== 1'b0 || cwp !== 2'd2) begin
      bad++; $display("FAIL fill_stack got=sp %0d ovf %0h cwp %0h want=16 0 2",
                      dut.u_stack.r_sp, ovf, cwp); end
    pulse(1'b1, 1'b0, bc);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h want=1", ovf); end
    total++; if (dut.u_stack.r_sp !== 5'd16 || cwp !== 2'd2 || bc !== 0) begin
      bad++; $display("FAIL ovf_state got=sp %0d cwp %0h busy %0d want=16 2 0",
                      dut.u_stack.r_sp, cwp, bc); end
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL unf_sticky got=%0h want=1", unf); end
  endtask

  task automatic test_noop();
    int bc;
    do_reset();
    write_reg(2'd0, 16'h1111);
    pulse(1'b1, 1'b1, bc);
    total++; if (cwp !== 2'd0 || dut.r_resident !== 2'd1 || ovf !== 1'b0 || unf !== 1'b0) begin
      bad++; $display("FAIL both_noop got=cwp %0h res %0h ovf %0h unf %0h want=0 1 0 0",
                      cwp, dut.r_resident, ovf, unf); end
    pulse(1'b1, 1'b0, bc);
    pulse(1'b1, 1'b0, bc);
    win_inc = 1'b1;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hDEAD;
    bc = 0;
    while (busy && bc < 8) begin
      bc++;
      @(negedge clk);
    end
    clr_in();
    total++; if (bc !== 2 || cwp !== 2'd3) begin
      bad++; $display("FAIL busy_ignore got=busy %0d cwp %0h want=2 3", bc, cwp); end
    total++; if (dut.r_regs[4] !== 16'h0) begin
      bad++; $display("FAIL busy_write got=%0h want=0", dut.r_regs[4]); end
    total++; if (dut.u_stack.r_sp !== 5'd2 || dut.u_stack.r_mem[0] !== 16'h1111) begin
      bad++; $display("FAIL busy_stack got=sp %0d m0 %0h want=2 1111",
                      dut.u_stack.r_sp, dut.u_stack.r_mem[0]); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_r2;
`ifdef WRF_BYPASS_EN
    exp_r2 = 16'hBEEF;
`else
    exp_r2 = 16'h0101;
`endif
    do_reset();
    write_reg(2'd1, 16'h0101);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'hBEEF; r2_addr = 2'd1; r1_addr = 2'd0;
    #1;
    total++; if (r2 !== exp_r2) begin bad++; $display("FAIL byp_r2 got=%0h want=%0h", r2, exp_r2); end
    total++; if (r1 !== 16'h0) begin bad++; $display("FAIL byp_r1 got=%0h want=0", r1); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    total++; if (r2 !== 16'hBEEF) begin bad++; $display("FAIL byp_after got=%0h want=beef", r2); end
  endtask

  task automatic test_reset_abort();
    int bc;
    do_reset();
    write_reg(2'd0, 16'h7777);
    pulse(1'b1, 1'b0, bc);
    pulse(1'b1, 1'b0, bc);
    win_inc = 1'b1;
    @(negedge clk);
    win_inc = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || dut.u_stack.r_mem[0] !== 16'h7777) begin
      bad++; $display("FAIL abort_mid got=busy %0h m0 %0h want=1 7777",
                      busy, dut.u_stack.r_mem[0]); end
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || cwp !== 2'd0 || dut.r_resident !== 2'd1) begin
      bad++; $display("FAIL abort_ctl got=busy %0h cwp %0h res %0h want=0 0 1",
                      busy, cwp, dut.r_resident); end
    total++; if (dut.u_stack.r_sp !== 5'd0 || dut.u_stack.r_mem[0] !== 16'h0 ||
                 dut.r_regs[0] !== 16'h0) begin
      bad++; $display("FAIL abort_data got=sp %0d m0 %0h p0 %0h want=0 0 0",
                      dut.u_stack.r_sp, dut.u_stack.r_mem[0], dut.r_regs[0]); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_after got=%0h want=0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    test_reset();
    test_overlap();
    test_spill_fill();
    test_unf_ovf();
    test_noop();
    test_bypass();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
